cu_flash_core: RTL and testbench
================================

Name: cu_flash_core

Overview:
- Single-clock core slice that merges three functions: the clock-enable gate (mc), a byte-wide flash-style program memory (flash), and the control-unit state machine with instruction decoder (cu).
- The external sequencer writes program bytes, reads them back byte by byte, assembles a 32-bit word and presents it on instruction with instr_valid.
- The block steps FETCH/DECODE/EXECUTE/MEMORY, decodes RV32I fields, and drops program_running on the all-zero halt word.

Parameters:
- MEM_ADDR_BITS, 10: implemented storage is 2^MEM_ADDR_BITS bytes. Upper address bits are ignored, so addresses alias.
- HALT_WORD, 32'h00000000: instruction value that stops the program.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- clk_en  in  1  global enable. When 0, all registers hold.
- cs  in  1  memory chip select.
- we  in  1  memory write enable.
- re  in  1  memory read enable.
- addr  in  24  byte address.
- din  in  8  write data.
- dout  out  8  registered read data.
- instruction  in  32  assembled instruction word.
- instr_valid  in  1  one-cycle pulse: instruction is valid.
- program_running  out  1  high until a halt is decoded.
- current_state  out  2  FETCH=00, DECODE=01, EXECUTE=10, MEMORY=11.
- opcode  out  7  instruction[6:0].
- rd  out  5  instruction[11:7].
- rs1  out  5  instruction[19:15].
- rs2  out  5  instruction[24:20].
- funct3  out  3  instruction[14:12].
- funct7  out  7  instruction[31:25].
- imm  out  32  sign-extended immediate.
- instr_type  out  3  R=000, I=001, S=010, B=011, U=100, J=101, unknown=111.

Behaviour:
- All registers update only on a rising clk edge with clk_en=1. rst is checked first and is effective even when clk_en=0.
- Reset (rst=0) values:
  - dout=0, current_state=FETCH, program_running=1.
  - All decode outputs are 0; instr_type=000.
  - Memory array is not cleared.
- Memory write: on an edge with cs=1 and we=1, mem[addr[MEM_ADDR_BITS-1:0]] is set to din. we takes priority over re, and dout holds during a write.
- Memory read: on an edge with cs=1, re=1 and we=0, dout is loaded with the mem byte. Data is valid after the edge (1-cycle latency). Otherwise dout holds its last value.
- Read-after-write to the same address on the next cycle returns the new byte.
- FSM transitions (only while program_running=1):
  - FETCH: wait for instr_valid=1, then go to DECODE. The instruction is captured into an internal IR on that edge.
  - DECODE: if IR==HALT_WORD, clear program_running, go to FETCH and freeze. Otherwise latch the decode outputs and go to EXECUTE.
  - EXECUTE: go to MEMORY after one cycle.
  - MEMORY: go to FETCH after one cycle.
- instr_valid outside FETCH is ignored.
- Once halted, the FSM stays in FETCH with program_running=0 until reset. Memory stays fully accessible.
- Decode fields come straight from IR. imm by opcode:
  - R (0110011): imm=0.
  - I (0010011, 0000011, 1100111): sext(IR[31:20]).
  - S (0100011): sext({IR[31:25], IR[11:7]}).
  - B (1100011): sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - U (0110111, 0010111): {IR[31:12], 12'b0}.
  - J (1101111): sext({IR[31], IR[19:12], IR[20], IR[30:21], 0}).
  - Any other opcode: instr_type=111, imm=0.
- Decode outputs are valid from EXECUTE entry and hold until the next DECODE.
- Reset mid-operation returns to the reset values on the next edge. The memory contents survive the reset.

Test Plan:
- Write bytes 83,02,00,02 to addresses 0..3, then read address 2 with cs=re=1 -> dout=8'h00 one cycle later. Read address 3 -> dout=8'h02.
- Write to address 0x000400 with MEM_ADDR_BITS=10, then read address 0 -> same byte (alias).
- Present 32'h02000283 with an instr_valid pulse -> DECODE then EXECUTE, with:
  - opcode=0000011, rd=5, rs1=0, funct3=0;
  - imm=32'h00000020, instr_type=001;
  - then MEMORY, then FETCH.
- Present 32'hFE000EE3 -> instr_type=011, imm=32'hFFFFFFFC, rs1=rs2=0.
- Present 32'h00000000 -> program_running goes 0 at the DECODE edge and the state stays 00. A later instr_valid pulse causes no change.
- Hold clk_en=0 for 5 cycles mid-EXECUTE -> state and dout are frozen. Pull rst=0 for one edge -> state=00, program_running=1, dout=0.

Source files
------------

// File: rtl/cu_flash_core_if.sv
// Bus bundle for cu_flash_core: byte memory port, instruction hand-off and decode results.
// The sequencer side is the master; the core is the slave.
interface cu_flash_core_if;
    logic        cs;
    logic        we;
    logic        re;
    logic [23:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        program_running;
    logic [1:0]  current_state;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  instr_type;

    modport master (
        output cs, we, re, addr, din, instruction, instr_valid,
        input  dout, program_running, current_state, opcode, rd, rs1, rs2,
               funct3, funct7, imm, instr_type
    );

    modport slave (
        input  cs, we, re, addr, din, instruction, instr_valid,
        output dout, program_running, current_state, opcode, rd, rs1, rs2,
               funct3, funct7, imm, instr_type
    );
endinterface

// File: rtl/cu_flash_core.sv
// Core slice: clock-enable gated byte program memory plus a FETCH/DECODE/EXECUTE/MEMORY
// control unit with an RV32I field and immediate decoder.
module cu_flash_core #(
    parameter int          MEM_ADDR_BITS = 10,
    parameter logic [31:0] HALT_WORD     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    cu_flash_core_if.slave     bus
);
    typedef enum logic [1:0] {FETCH = 2'b00, DECODE = 2'b01, EXECUTE = 2'b10, MEMORY = 2'b11} state_t;

    logic [7:0]               mem_q [0:(2**MEM_ADDR_BITS)-1];
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [7:0]               dout_q;
    logic                     addr_unused;

    // Upper address bits are dropped so the storage aliases across the 24-bit space.
    assign mem_addr    = bus.addr[MEM_ADDR_BITS-1:0];
    assign addr_unused = &{1'b0, bus.addr[23:MEM_ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (clk_en && bus.cs && bus.we)
            mem_q[mem_addr] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            dout_q <= 8'h00;
        else if (clk_en && bus.cs && bus.re && !bus.we)
            dout_q <= mem_q[mem_addr];
    end

    state_t      state_q, state_d;
    logic        running_q, running_d;
    logic [31:0] ir_q, ir_d;
    logic [6:0]  opcode_q, opcode_d, funct7_q, funct7_d;
    logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d, type_q, type_d, type_c;
    logic [31:0] imm_q, imm_d, imm_c;

    always_comb begin
        type_c = 3'b111;
        imm_c  = 32'h0;
        case (ir_q[6:0])
            7'b0110011: type_c = 3'b000;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                type_c = 3'b001;
                imm_c  = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            7'b0100011: begin
                type_c = 3'b010;
                imm_c  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            7'b1100011: begin
                type_c = 3'b011;
                imm_c  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                type_c = 3'b100;
                imm_c  = {ir_q[31:12], 12'h000};
            end
            7'b1101111: begin
                type_c = 3'b101;
                imm_c  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        imm_d     = imm_q;
        type_d    = type_q;
        if (running_q) begin
            case (state_q)
                FETCH: if (bus.instr_valid) begin
                    ir_d    = bus.instruction;
                    state_d = DECODE;
                end
                DECODE: if (ir_q == HALT_WORD) begin
                    running_d = 1'b0;
                    state_d   = FETCH;
                end else begin
                    opcode_d = ir_q[6:0];
                    rd_d     = ir_q[11:7];
                    funct3_d = ir_q[14:12];
                    rs1_d    = ir_q[19:15];
                    rs2_d    = ir_q[24:20];
                    funct7_d = ir_q[31:25];
                    imm_d    = imm_c;
                    type_d   = type_c;
                    state_d  = EXECUTE;
                end
                EXECUTE: state_d = MEMORY;
                MEMORY:  state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            running_q <= 1'b1;
            ir_q      <= 32'h0;
            opcode_q  <= 7'h0;
            rd_q      <= 5'h0;
            rs1_q     <= 5'h0;
            rs2_q     <= 5'h0;
            funct3_q  <= 3'h0;
            funct7_q  <= 7'h0;
            imm_q     <= 32'h0;
            type_q    <= 3'b000;
        end else if (clk_en) begin
            state_q   <= state_d;
            running_q <= running_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            imm_q     <= imm_d;
            type_q    <= type_d;
        end
    end

    assign bus.dout            = dout_q;
    assign bus.program_running = running_q;
    assign bus.current_state   = state_q;
    assign bus.opcode          = opcode_q;
    assign bus.rd              = rd_q;
    assign bus.rs1             = rs1_q;
    assign bus.rs2             = rs2_q;
    assign bus.funct3          = funct3_q;
    assign bus.funct7          = funct7_q;
    assign bus.imm             = imm_q;
    assign bus.instr_type      = type_q;
endmodule

// File: tb/tb_cu_flash_core.sv
// Directed bench for cu_flash_core: memory write/read/alias, decode of several formats,
// clock-enable freeze, reset recovery and halt behaviour.
module tb_cu_flash_core;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_cmp = 0;
    int   n_bad = 0;

    cu_flash_core_if bus_if();

    cu_flash_core #(.MEM_ADDR_BITS(10), .HALT_WORD(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic mem_write(input logic [23:0] a, input logic [7:0] d);
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.re = 1'b0;
        bus_if.addr = a; bus_if.din = d;
        tick();
        bus_if.cs = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic mem_read(input logic [23:0] a);
        bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.re = 1'b1;
        bus_if.addr = a;
        tick();
        bus_if.cs = 1'b0; bus_if.re = 1'b0;
    endtask

    // Pulses instr_valid in FETCH and leaves the core in EXECUTE.
    task automatic run_to_execute(input logic [31:0] w);
        bus_if.instruction = w; bus_if.instr_valid = 1'b1;
        tick();
        bus_if.instr_valid = 1'b0;
        chk("state_decode", {30'h0, bus_if.current_state}, 32'h1);
        tick();
        chk("state_execute", {30'h0, bus_if.current_state}, 32'h2);
    endtask

    initial begin
        rst = 1'b0; clk_en = 1'b1;
        bus_if.cs = 0; bus_if.we = 0; bus_if.re = 0; bus_if.addr = '0; bus_if.din = '0;
        bus_if.instruction = '0; bus_if.instr_valid = 0;
        tick(); tick();
        chk("rst_dout", {24'h0, bus_if.dout}, 32'h0);
        chk("rst_state", {30'h0, bus_if.current_state}, 32'h0);
        chk("rst_running", {31'h0, bus_if.program_running}, 32'h1);
        chk("rst_type", {29'h0, bus_if.instr_type}, 32'h0);
        chk("rst_imm", bus_if.imm, 32'h0);
        rst = 1'b1;

        mem_write(24'd0, 8'h83); mem_write(24'd1, 8'h02);
        mem_write(24'd2, 8'h00); mem_write(24'd3, 8'h02);
        mem_read(24'd2); chk("rd_addr2", {24'h0, bus_if.dout}, 32'h00);
        mem_read(24'd3); chk("rd_addr3", {24'h0, bus_if.dout}, 32'h02);
        mem_read(24'd0); chk("rd_addr0", {24'h0, bus_if.dout}, 32'h83);

        // write with re also high: dout must hold, then next-cycle read returns new byte
        bus_if.cs = 1; bus_if.we = 1; bus_if.re = 1; bus_if.addr = 24'd5; bus_if.din = 8'hAA;
        tick();
        chk("dout_hold_on_wr", {24'h0, bus_if.dout}, 32'h83);
        bus_if.we = 0;
        tick();
        chk("raw_addr5", {24'h0, bus_if.dout}, 32'hAA);
        bus_if.cs = 0; bus_if.re = 0;

        mem_write(24'h000400, 8'h5A);
        mem_read(24'd0); chk("alias_addr0", {24'h0, bus_if.dout}, 32'h5A);

        // I-type load
        run_to_execute(32'h02000283);
        chk("lw_opcode", {25'h0, bus_if.opcode}, 32'h03);
        chk("lw_rd", {27'h0, bus_if.rd}, 32'd5);
        chk("lw_rs1", {27'h0, bus_if.rs1}, 32'd0);
        chk("lw_funct3", {29'h0, bus_if.funct3}, 32'd0);
        chk("lw_imm", bus_if.imm, 32'h00000020);
        chk("lw_type", {29'h0, bus_if.instr_type}, 32'h1);
        bus_if.instruction = 32'h0000000F; bus_if.instr_valid = 1;   // must be ignored outside FETCH
        tick();
        bus_if.instr_valid = 0;
        chk("state_memory", {30'h0, bus_if.current_state}, 32'h3);
        chk("ignored_type", {29'h0, bus_if.instr_type}, 32'h1);
        tick();
        chk("state_fetch", {30'h0, bus_if.current_state}, 32'h0);
        tick();
        chk("fetch_wait", {30'h0, bus_if.current_state}, 32'h0);

        // B-type
        run_to_execute(32'hFE000EE3);
        chk("b_type", {29'h0, bus_if.instr_type}, 32'h3);
        chk("b_imm", bus_if.imm, 32'hFFFFFFFC);
        chk("b_rs1", {27'h0, bus_if.rs1}, 32'd0);
        chk("b_rs2", {27'h0, bus_if.rs2}, 32'd0);
        chk("b_funct7", {25'h0, bus_if.funct7}, 32'h7F);
        tick(); tick();

        // S-type
        run_to_execute(32'h00512223);
        chk("s_type", {29'h0, bus_if.instr_type}, 32'h2);
        chk("s_imm", bus_if.imm, 32'h4);
        chk("s_rs2", {27'h0, bus_if.rs2}, 32'd5);
        tick(); tick();

        // R-type
        run_to_execute(32'h00B50533);
        chk("r_type", {29'h0, bus_if.instr_type}, 32'h0);
        chk("r_imm", bus_if.imm, 32'h0);
        chk("r_rd", {27'h0, bus_if.rd}, 32'd10);
        chk("r_rs2", {27'h0, bus_if.rs2}, 32'd11);
        tick(); tick();

        // J-type: jal x1, -8
        run_to_execute(32'hFF9FF0EF);
        chk("j_type", {29'h0, bus_if.instr_type}, 32'h5);
        chk("j_imm", bus_if.imm, 32'hFFFFFFF8);
        tick(); tick();

        // unknown opcode
        run_to_execute(32'h0000000F);
        chk("unk_type", {29'h0, bus_if.instr_type}, 32'h7);
        chk("unk_imm", bus_if.imm, 32'h0);
        tick(); tick();

        // U-type, then freeze in EXECUTE
        mem_read(24'd3);
        run_to_execute(32'h12345037);
        chk("u_type", {29'h0, bus_if.instr_type}, 32'h4);
        chk("u_imm", bus_if.imm, 32'h12345000);
        clk_en = 0;
        bus_if.cs = 1; bus_if.re = 1; bus_if.addr = 24'd0;
        for (int i = 0; i < 5; i++) tick();
        chk("frz_state", {30'h0, bus_if.current_state}, 32'h2);
        chk("frz_dout", {24'h0, bus_if.dout}, 32'h02);
        rst = 0;
        tick();
        chk("rst2_state", {30'h0, bus_if.current_state}, 32'h0);
        chk("rst2_running", {31'h0, bus_if.program_running}, 32'h1);
        chk("rst2_dout", {24'h0, bus_if.dout}, 32'h0);
        chk("rst2_imm", bus_if.imm, 32'h0);
        rst = 1; clk_en = 1; bus_if.cs = 0; bus_if.re = 0;
        mem_read(24'd1); chk("mem_survives", {24'h0, bus_if.dout}, 32'h02);

        // halt word
        bus_if.instruction = 32'h0; bus_if.instr_valid = 1;
        tick();
        bus_if.instr_valid = 0;
        chk("halt_decode", {30'h0, bus_if.current_state}, 32'h1);
        tick();
        chk("halt_running", {31'h0, bus_if.program_running}, 32'h0);
        chk("halt_state", {30'h0, bus_if.current_state}, 32'h0);
        bus_if.instruction = 32'h02000283; bus_if.instr_valid = 1;
        tick();
        bus_if.instr_valid = 0;
        tick();
        chk("halted_state", {30'h0, bus_if.current_state}, 32'h0);
        chk("halted_running", {31'h0, bus_if.program_running}, 32'h0);
        mem_write(24'd7, 8'h3C);
        mem_read(24'd7); chk("halted_mem", {24'h0, bus_if.dout}, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
